// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, one held instruction, redirect squashes old path.
// Latency: 1 cycle rst-release/redirect to request, ack to inst_valid; holds until inst_ready, memory stalls via imem_ack.
module fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] req_addr;
   logic [31:0] tgt;

   assign tgt       = redirect_pc & 32'hFFFF_FFFC;
   assign imem_req  = (state == REQ) || (state == FLUSH);
   assign imem_addr = req_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_VECTOR;
         req_addr   <= RESET_VECTOR;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
         inst_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               if (redirect) begin
                  pc       <= tgt;
                  req_addr <= tgt;
               end else begin
                  req_addr <= pc;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  if (redirect) begin
                     pc       <= tgt;
                     req_addr <= tgt;
                  end else begin
                     inst       <= imem_rdata;
                     inst_pc    <= req_addr;
                     inst_valid <= 1'b1;
                     pc         <= req_addr + 32'd4;
                     state      <= HOLD;
                  end
               end else if (redirect) begin
                  pc    <= tgt;
                  state <= FLUSH;
               end
            end
            HOLD: begin
               if (redirect) begin
                  inst_valid <= 1'b0;
                  pc         <= tgt;
                  req_addr   <= tgt;
                  state      <= REQ;
               end else if (inst_ready) begin
                  inst_valid <= 1'b0;
                  req_addr   <= pc;
                  state      <= REQ;
               end
            end
            FLUSH: begin
               // the old request cannot be withdrawn; only its ack releases us
               if (redirect)
                  pc <= tgt;
               if (imem_ack) begin
                  req_addr <= redirect ? tgt : pc;
                  state    <= REQ;
               end
            end
            default: begin
               state      <= IDLE;
               inst_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic against a flag-based fetch model.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic [31:0] pc;

   int errors = 0;
   int checks = 0;

   // model: busy = request outstanding, squash = outstanding request is stale, hold = instruction parked
   logic        m_busy, m_squash, m_hold;
   logic [31:0] m_pc, m_addr, m_inst, m_inst_pc;

   fetch_ctrl #(.RESET_VECTOR(32'h0)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
      .inst_pc(inst_pc), .inst_ready(inst_ready), .pc(pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      logic [31:0] t;
      t = redirect_pc & ~32'h3;
      if (rst) begin
         m_busy = 0; m_squash = 0; m_hold = 0;
         m_pc = 0; m_addr = 0; m_inst = 0; m_inst_pc = 0;
      end else if (!m_busy && !m_hold) begin
         m_busy = 1;
         if (redirect) m_pc = t;
         m_addr = m_pc;
      end else if (m_busy) begin
         if (imem_ack) begin
            if (m_squash || redirect) begin
               m_squash = 0;
               if (redirect) m_pc = t;
               m_addr = m_pc;
            end else begin
               m_inst = m_addr ^ 32'hA5A5_0000;
               m_inst_pc = m_addr;
               m_pc = m_addr + 32'd4;
               m_busy = 0;
               m_hold = 1;
            end
         end else if (redirect) begin
            m_pc = t;
            m_squash = 1;
         end
      end else if (redirect || inst_ready) begin
         m_hold = 0;
         if (redirect) m_pc = t;
         m_addr = m_pc;
         m_busy = 1;
      end
   endtask

   // drive at negedge, update model at posedge, compare at the following negedge
   task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic ack, input logic rdy);
      rst = r;
      redirect = rd;
      redirect_pc = rpc;
      imem_ack = ack & imem_req;
      imem_rdata = m_addr ^ 32'hA5A5_0000;
      inst_ready = rdy;
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
      chk("imem_addr", imem_addr, m_busy ? m_addr : imem_addr);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
      chk("pc", pc, m_pc);
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_inst_pc);
   endtask

   initial begin
      int n;
      rst = 1; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0; inst_ready = 0;
      m_busy = 0; m_squash = 0; m_hold = 0;
      m_pc = 0; m_addr = 0; m_inst = 0; m_inst_pc = 0;
      @(negedge clk);

      // reset and first request
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      step(0, 0, 0, 0, 0);
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      // zero-wait sequential fetch
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);
      chk("seq_inst_pc", inst_pc, 32'hC);

      // wait states then decode stall
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h10);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
      chk("stall_inst_pc", inst_pc, 32'h10);
      chk("stall_noreq", {31'b0, imem_req}, 32'd0);
      step(0, 0, 0, 1, 1);

      // redirect while holding inst from 0x4 (pc 0x8)
      step(1, 0, 0, 0, 0);
      n = 0;
      step(0, 0, 0, 0, 0);
      while (!(m_hold && m_inst_pc == 32'h4) && n < 20) begin
         step(0, 0, 0, 1, 1);
         n++;
      end
      chk("hold_pc", pc, 32'h8);
      step(0, 1, 32'h23, 0, 1);
      chk("redir_addr", imem_addr, 32'h20);
      chk("redir_valid", {31'b0, inst_valid}, 32'd0);

      // redirect with pending request, then inside the flush window
      step(0, 1, 32'h10, 1, 1);
      chk("req10", imem_addr, 32'h10);
      step(0, 1, 32'h100, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("flush_addr", imem_addr, 32'h10);
      step(0, 1, 32'h200, 0, 1);
      step(0, 0, 0, 1, 1);
      chk("flush_next", imem_addr, 32'h200);
      chk("flush_valid", {31'b0, inst_valid}, 32'd0);

      // wrap and mid-request reset
      step(0, 1, 32'hFFFF_FFFF, 1, 1);
      step(0, 0, 0, 1, 0);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      chk("midrst_req", {31'b0, imem_req}, 32'd0);
      chk("midrst_pc", pc, 32'h0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
              $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request port. Sits between the PC register and decode. Issues one fetch at a time, holds the fetched instruction until decode accepts it, and applies branch/jump redirects from execute, squashing any in-flight or held instruction on the old path.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset (bits [1:0] must be 0)
- `clk` in 1: clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `redirect` in 1: branch/jump taken; overrides sequential PC
- `redirect_pc` in 32: redirect target; bits [1:0] ignored and forced to 0
- `imem_req` out 1: fetch request valid
- `imem_addr` out 32: fetch address; stable while `imem_req`=1 and `imem_ack`=0
- `imem_ack` in 1: memory accepts request and returns `imem_rdata` this cycle
- `imem_rdata` in 32: instruction word, valid only when `imem_ack`=1
- `inst_valid` out 1: `inst`/`inst_pc` hold a valid instruction for decode
- `inst` out 32: fetched instruction
- `inst_pc` out 32: address `inst` was fetched from
- `inst_ready` in 1: decode consumes `inst` this cycle when `inst_valid`=1
- `pc` out 32: architectural next-fetch PC

## Operation
- Registers: `pc`, `req_addr` (drives `imem_addr`), `inst`, `inst_pc`, `inst_valid`, 2-bit state.
- States: IDLE, REQ, HOLD, FLUSH.
- IDLE: entered only from reset. Next cycle -> REQ with `req_addr`<=`pc`. Redirect in IDLE: `pc`<=`redirect_pc`, `req_addr`<=`redirect_pc`.
- REQ: `imem_req`=1, `imem_addr`=`req_addr`.
  - ack, no redirect: `inst`<=`imem_rdata`, `inst_pc`<=`req_addr`, `inst_valid`<=1, `pc`<=`req_addr`+4 -> HOLD.
  - ack + redirect: data discarded, `pc`<=`req_addr`<=`redirect_pc` -> REQ.
  - no ack + redirect: `pc`<=`redirect_pc` -> FLUSH (`req_addr` unchanged, request stays up).
  - no ack, no redirect: stay.
- HOLD: `imem_req`=0, `inst_valid`=1.
  - redirect (priority over `inst_ready`): `inst_valid`<=0, `pc`<=`req_addr`<=`redirect_pc` -> REQ.
  - `inst_ready`: `inst_valid`<=0, `req_addr`<=`pc` -> REQ.
  - else stay; `inst`/`inst_pc` frozen.
- FLUSH: `imem_req`=1 at old `req_addr` (bus protocol forbids withdrawal). Redirect updates `pc` only, stays FLUSH (last redirect wins). On ack: data discarded, `req_addr`<=`pc` (or `redirect_pc` if redirect same cycle) -> REQ.
- Arithmetic: `pc`+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0. No misalignment traps.
- Unreachable state encoding -> IDLE.

## Timing
- Reset values: state IDLE, `pc`=`req_addr`=`imem_addr`=RESET_VECTOR, `imem_req`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0.
- `imem_req`, `imem_addr`, `inst_valid`, `inst`, `inst_pc`, `pc` are direct register/state decodes; no combinational path from any input.
- First request: cycle 1 after `rst` deasserts. Zero-wait ack -> `inst_valid` next cycle.
- Zero-wait memory, `inst_ready` tied 1: one instruction per 2 cycles (REQ, HOLD alternate).
- Redirect-to-new-request latency: 1 cycle from REQ/HOLD/IDLE; from FLUSH, 1 cycle after old ack.
- `rst` wins over all inputs; mid-request reset drops the request next cycle with no ack required.

## Test plan
- Reset: hold `rst` 2 cycles, release -> `imem_req`=0, `pc`=0 during reset; `imem_req`=1, `imem_addr`=0 one cycle after release.
- Sequential, zero-wait ack, `inst_ready`=1, rdata=addr^32'hA5A5_0000 -> `inst_pc` sequence 0,4,8,C with matching `inst`, `inst_valid` every other cycle.
- Wait states + stall: ack after 3 cycles, `inst_ready`=0 for 4 cycles -> `imem_addr` stable during wait, `inst`/`inst_pc` frozen, no new request until consumed.
- Redirect in HOLD: holding pc 0x8, `redirect`=1 to 0x23 -> `inst_valid` drops, next `imem_addr`=0x20, no instruction from 0xC ever valid.
- Redirect during pending request: REQ at 0x10 unacked, redirect to 0x100 -> `imem_addr` stays 0x10 until ack, data discarded, next request 0x100; second redirect to 0x200 while in FLUSH -> next request 0x200.
- Wrap/reset: redirect to 0xFFFF_FFFC, ack -> `pc`=0; assert `rst` while `imem_req`=1 -> next cycle `imem_req`=0, `pc`=RESET_VECTOR.
